// File: rtl/square_calc_pkg.sv
// square_calc_pkg: widths, default constants, FSM encoding and the
// controller-to-datapath control bundle shared by the squarer files.
package square_calc_pkg;

    localparam int ROOT_WIDTH   = 8;
    localparam int SQUARE_WIDTH = 2 * ROOT_WIDTH;
    localparam int ODD_WIDTH    = ROOT_WIDTH + 1;

    localparam int unsigned ODD_INIT_DEF = 1;
    localparam int unsigned ODD_INC_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic boot;
        logic wr_square;
        logic wr_odd;
        logic wr_count;
    } ctrl_t;

endpackage

// File: rtl/square_calc_if.sv
// square_calc_if: request/result bundle of the squarer.
// master drives start_i/root_i; slave returns square_o, busy_o, done_o.
interface square_calc_if;
    import square_calc_pkg::*;

    logic                    start_i;
    logic [ROOT_WIDTH-1:0]   root_i;
    logic [SQUARE_WIDTH-1:0] square_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        output start_i, root_i,
        input  square_o, busy_o, done_o
    );

    modport slave (
        input  start_i, root_i,
        output square_o, busy_o, done_o
    );

endinterface

// File: rtl/square_calc_datapath.sv
// square_calc_datapath: square/odd/count registers with boot muxes,
// adder, decrementer and count==0 flag. Ports: clk, rst_n, ctrl, root_i, square_o, z_o.
module gen_reg #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule

module mux_2_1 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

module square_calc_datapath
    import square_calc_pkg::*;
#(
    parameter int unsigned ODD_INIT = ODD_INIT_DEF,
    parameter int unsigned ODD_INC  = ODD_INC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  ctrl_t                   ctrl,
    input  logic [ROOT_WIDTH-1:0]   root_i,
    output logic [SQUARE_WIDTH-1:0] square_o,
    output logic                    z_o
);
    localparam logic [ODD_WIDTH-1:0] ODD_INIT_V = ODD_WIDTH'(ODD_INIT);
    localparam logic [ODD_WIDTH-1:0] ODD_INC_V  = ODD_WIDTH'(ODD_INC);

    logic [SQUARE_WIDTH-1:0] square_q, square_sum, square_d;
    logic [ODD_WIDTH-1:0]    odd_q, odd_sum, odd_d;
    logic [ROOT_WIDTH-1:0]   count_q, count_dec, count_d;

    assign square_sum = square_q + SQUARE_WIDTH'(odd_q);
    assign odd_sum    = odd_q + ODD_INC_V;
    assign count_dec  = count_q - ROOT_WIDTH'(1);

    // boot=1 loads the start values, boot=0 takes the iteration step
    mux_2_1 #(.WIDTH(SQUARE_WIDTH)) u_mux_square (
        .sel (ctrl.boot),
        .a   (square_sum),
        .b   ('0),
        .y   (square_d)
    );

    mux_2_1 #(.WIDTH(ODD_WIDTH)) u_mux_odd (
        .sel (ctrl.boot),
        .a   (odd_sum),
        .b   (ODD_INIT_V),
        .y   (odd_d)
    );

    mux_2_1 #(.WIDTH(ROOT_WIDTH)) u_mux_count (
        .sel (ctrl.boot),
        .a   (count_dec),
        .b   (root_i),
        .y   (count_d)
    );

    gen_reg #(.WIDTH(SQUARE_WIDTH), .RST_VAL('0)) u_reg_square (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.wr_square),
        .d     (square_d),
        .q     (square_q)
    );

    gen_reg #(.WIDTH(ODD_WIDTH), .RST_VAL(ODD_INIT_V)) u_reg_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.wr_odd),
        .d     (odd_d),
        .q     (odd_q)
    );

    gen_reg #(.WIDTH(ROOT_WIDTH), .RST_VAL('0)) u_reg_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.wr_count),
        .d     (count_d),
        .q     (count_q)
    );

    assign square_o = square_q;
    assign z_o      = (count_q == '0);

endmodule

// File: rtl/square_calc.sv
// square_calc: sequential squarer, square_o = root_i^2 by summing the
// first root_i odd numbers. Ports: clk, rst_n, bus (square_calc_if.slave).
module square_calc
    import square_calc_pkg::*;
#(
    parameter int unsigned ODD_INIT = ODD_INIT_DEF,
    parameter int unsigned ODD_INC  = ODD_INC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    square_calc_if.slave bus
);
    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // the unused encoding 2'd3 falls into default and acts as IDLE
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            CALC: begin
                if (z) begin
                    state_d = DONE;
                end else begin
                    ctrl.wr_square = 1'b1;
                    ctrl.wr_odd    = 1'b1;
                    ctrl.wr_count  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (bus.start_i) begin
                    state_d        = CALC;
                    ctrl.boot      = 1'b1;
                    ctrl.wr_square = 1'b1;
                    ctrl.wr_odd    = 1'b1;
                    ctrl.wr_count  = 1'b1;
                end
            end
        endcase
    end

    square_calc_datapath #(
        .ODD_INIT (ODD_INIT),
        .ODD_INC  (ODD_INC)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (ctrl),
        .root_i   (bus.root_i),
        .square_o (bus.square_o),
        .z_o      (z)
    );

    assign bus.busy_o = (state_q == CALC) || (state_q == DONE);
    assign bus.done_o = (state_q == DONE);

endmodule

// File: tb/tb_square_calc.sv
// tb_square_calc: directed bench for square_calc with a cycle-level
// reference model, per-cycle comparison and literal result checks.
module tb_square_calc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    square_calc_if bus ();

    square_calc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: m_left = busy cycles still to come, last one is the done cycle
    int m_left = 0;
    int m_res  = 0;
    int m_held = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_held <= 0;
        end else if (m_left == 0) begin
            if (bus.start_i) begin
                m_left <= int'(bus.root_i) + 2;
                m_res  <= int'(bus.root_i) * int'(bus.root_i);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) m_held <= m_res;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", int'(bus.busy_o), int'(m_left > 0));
        chk("done", int'(bus.done_o), int'(m_left == 1));
        if (m_left == 1)      chk("square_done", int'(bus.square_o), m_res);
        else if (m_left == 0) chk("square_idle", int'(bus.square_o), m_held);
    end

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic do_op(input int r);
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.root_i  = 8'(r);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.root_i  = 8'($urandom);
    endtask

    // returns at the negedge of the done cycle; n0 = cycles already waited
    task automatic wait_done(input string name, input int exp_sq,
                             input int exp_lat, input int n0);
        int n = n0;
        bit seen = 0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done_o) seen = 1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_lat"}, n, exp_lat);
            chk({name, "_sq"}, int'(bus.square_o), exp_sq);
            chk({name, "_model"}, m_res, exp_sq);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.root_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_sq", int'(bus.square_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(0);
        wait_done("r0", 0, 2, 0);

        do_op(12);
        wait_done("r12", 144, 14, 0);
        do_op(255);
        wait_done("r255", 65025, 257, 0);

        // starts during CALC and DONE are ignored
        do_op(5);
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1;
        bus.root_i  = 8'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("r5", 25, 7, 4);
        bus.start_i = 1'b1;
        bus.root_i  = 8'd9;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        chk("r5_idle_busy", int'(bus.busy_o), 0);
        chk("r5_idle_sq", int'(bus.square_o), 25);
        do_op(9);
        wait_done("r9", 81, 11, 0);

        // reset in the middle of a long computation
        do_op(200);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_done", int'(bus.done_o), 0);
        chk("mid_rst_sq", int'(bus.square_o), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(3);
        wait_done("r3_after_rst", 9, 5, 0);

        // start held high: one result every r+3 cycles
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.root_i  = 8'd3;
        wait_done("bb0", 9, 6, 0);
        wait_done("bb1", 9, 6, 0);
        wait_done("bb2", 9, 6, 0);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);

        // full sweep, result fed to a reference square root
        for (int r = 0; r < 256; r++) begin
            do_op(r);
            wait_done("sweep", r * r, r + 2, 0);
            chk("sweep_sqrt", isqrt(int'(bus.square_o)), r);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
